// File: rtl/ladybug_coin_cond.sv
// rtl/ladybug_coin_cond.sv - two-channel coin input conditioner (sync, debounce, pulse shaping, counting)
//
// Each coin button is synchronized to clk_sys, debounced, and converted into
// a single fixed-length chute pulse per accepted coin. A held coin produces
// exactly one pulse; the line must read low for a full debounce period before
// another coin can be accepted. Timing counters advance only on ce_i ticks.
//
// Optional feature: define LADYBUG_COIN_LOCKOUT_EN to add lockout_i, which
// keeps idle channels from accepting new coins (channels already busy finish).
//
// Parameters:
//   DEBOUNCE_CNT  ce_i ticks an input level must be stable to be accepted (>= 2)
//   PULSE_CNT     ce_i ticks the chute output stays high (>= 2)
//
// Ports:
//   clk_sys        system clock, single domain
//   reset          synchronous active-high reset
//   ce_i           count enable for all timing counters
//   coin_i[1:0]    raw coin buttons; bit0 -> right chute, bit1 -> left chute
//   lockout_i      coin lockout request (LADYBUG_COIN_LOCKOUT_EN only)
//   right_chute_o  registered coin pulse, channel 0
//   left_chute_o   registered coin pulse, channel 1
//   coin_cnt0_o    accepted-coin count, channel 0 (wraps 255 -> 0)
//   coin_cnt1_o    accepted-coin count, channel 1 (wraps 255 -> 0)

module ladybug_coin_cond #(
  parameter int DEBOUNCE_CNT = 25000,
  parameter int PULSE_CNT    = 250000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_i,
  input  logic [1:0] coin_i,
`ifdef LADYBUG_COIN_LOCKOUT_EN
  input  logic       lockout_i,
`endif
  output logic       right_chute_o,
  output logic       left_chute_o,
  output logic [7:0] coin_cnt0_o,
  output logic [7:0] coin_cnt1_o
);

  // One shared counter per channel serves DEBOUNCE, PULSE and RELEASE, so it
  // is sized for the longer of the two periods.
  localparam int MAX_CNT = (DEBOUNCE_CNT > PULSE_CNT) ? DEBOUNCE_CNT : PULSE_CNT;
  localparam int CW      = $clog2(MAX_CNT);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] PUL_LAST = CW'(PULSE_CNT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PULSE    = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic          accept_ok;

  state_t        state_q    [2];
  state_t        state_d    [2];
  logic [CW-1:0] cnt_q      [2];
  logic [CW-1:0] cnt_d      [2];
  logic          coin_inc   [2];
  logic          chute_q    [2];
  logic [7:0]    coin_cnt_q [2];

`ifdef LADYBUG_COIN_LOCKOUT_EN
  assign accept_ok = ~lockout_i;
`else
  assign accept_ok = 1'b1;
`endif

  // Two-flop synchronizer for both raw coin lines.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= coin_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel next-state logic. Level-driven exits (DEBOUNCE abort,
  // RELEASE restart) are evaluated before the ce_i gate so they happen even
  // on cycles where the counters are frozen.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch]  = state_q[ch];
      cnt_d[ch]    = cnt_q[ch];
      coin_inc[ch] = 1'b0;

      case (state_q[ch])
        IDLE: begin
          if (sync2_q[ch] && accept_ok) begin
            state_d[ch] = DEBOUNCE;
            cnt_d[ch]   = '0;
          end
        end

        DEBOUNCE: begin
          if (!sync2_q[ch]) begin
            state_d[ch] = IDLE;
          end else if (ce_i) begin
            if (cnt_q[ch] == DEB_LAST) begin
              state_d[ch]  = PULSE;
              cnt_d[ch]    = '0;
              coin_inc[ch] = 1'b1;
            end else begin
              cnt_d[ch] = cnt_q[ch] + CW'(1);
            end
          end
        end

        PULSE: begin
          // Input level deliberately ignored here.
          if (ce_i) begin
            if (cnt_q[ch] == PUL_LAST) begin
              state_d[ch] = RELEASE;
              cnt_d[ch]   = '0;
            end else begin
              cnt_d[ch] = cnt_q[ch] + CW'(1);
            end
          end
        end

        RELEASE: begin
          // Counts consecutive low ticks; any high level starts over, so a
          // held button never re-arms the channel.
          if (sync2_q[ch]) begin
            cnt_d[ch] = '0;
          end else if (ce_i) begin
            if (cnt_q[ch] == DEB_LAST) begin
              state_d[ch] = IDLE;
              cnt_d[ch]   = '0;
            end else begin
              cnt_d[ch] = cnt_q[ch] + CW'(1);
            end
          end
        end

        default: begin
          state_d[ch] = IDLE;
          cnt_d[ch]   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs. The chute flop is loaded from
  // the next state so it rises on the same edge the FSM enters PULSE.
  always_ff @(posedge clk_sys) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (reset) begin
        state_q[ch]    <= IDLE;
        cnt_q[ch]      <= '0;
        chute_q[ch]    <= 1'b0;
        coin_cnt_q[ch] <= 8'd0;
      end else begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
        chute_q[ch] <= (state_d[ch] == PULSE);
        if (coin_inc[ch]) begin
          coin_cnt_q[ch] <= coin_cnt_q[ch] + 8'd1;
        end
      end
    end
  end

  assign right_chute_o = chute_q[0];
  assign left_chute_o  = chute_q[1];
  assign coin_cnt0_o   = coin_cnt_q[0];
  assign coin_cnt1_o   = coin_cnt_q[1];

endmodule

// File: tb/tb_ladybug_coin_cond.sv
// tb/tb_ladybug_coin_cond.sv - directed self-checking bench for ladybug_coin_cond
//
// Runs the conditioner with DEBOUNCE_CNT=4, PULSE_CNT=8. Inputs change and
// outputs are sampled on the falling clock edge. Index i in observe() counts
// falling edges after the one where the stimulus was applied.

module tb_ladybug_coin_cond;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ce_i    = 1'b1;
  logic [1:0] coin_i  = 2'b00;
`ifdef LADYBUG_COIN_LOCKOUT_EN
  logic       lockout_i = 1'b0;
`endif
  logic       right_chute_o;
  logic       left_chute_o;
  logic [7:0] coin_cnt0_o;
  logic [7:0] coin_cnt1_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  ladybug_coin_cond #(
    .DEBOUNCE_CNT(4),
    .PULSE_CNT   (8)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce_i         (ce_i),
    .coin_i       (coin_i),
`ifdef LADYBUG_COIN_LOCKOUT_EN
    .lockout_i    (lockout_i),
`endif
    .right_chute_o(right_chute_o),
    .left_chute_o (left_chute_o),
    .coin_cnt0_o  (coin_cnt0_o),
    .coin_cnt1_o  (coin_cnt1_o)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    coin_i = 2'b00;
    ce_i   = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // Steps n cycles and measures both chute outputs: index of first high
  // sample (-1 if none), number of high samples, number of rising edges and
  // number of samples where the two chutes disagree. ce_i is high on every
  // ce_div-th clock edge.
  task automatic observe(input int n, input int ce_div,
                         output int first_r, output int len_r, output int rises_r,
                         output int first_l, output int len_l, output int rises_l,
                         output int diff);
    logic prev_r;
    logic prev_l;
    prev_r  = right_chute_o;
    prev_l  = left_chute_o;
    first_r = -1; len_r = 0; rises_r = 0;
    first_l = -1; len_l = 0; rises_l = 0;
    diff    = 0;
    for (int i = 1; i <= n; i++) begin
      ce_i = ((i % ce_div) == 0);
      @(negedge clk_sys);
      if (right_chute_o) begin
        if (first_r < 0) first_r = i;
        len_r++;
        if (!prev_r) rises_r++;
      end
      if (left_chute_o) begin
        if (first_l < 0) first_l = i;
        len_l++;
        if (!prev_l) rises_l++;
      end
      if (right_chute_o !== left_chute_o) diff++;
      prev_r = right_chute_o;
      prev_l = left_chute_o;
    end
    ce_i = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    coin_i = 2'b11;
    step(3);
    n_tests++; if (right_chute_o !== 1'b0) begin n_fail++; $display("FAIL reset_right_chute: got %b expected 0", right_chute_o); end
    n_tests++; if (left_chute_o !== 1'b0) begin n_fail++; $display("FAIL reset_left_chute: got %b expected 0", left_chute_o); end
    n_tests++; if (coin_cnt0_o !== 8'd0) begin n_fail++; $display("FAIL reset_cnt0: got %0d expected 0", coin_cnt0_o); end
    n_tests++; if (coin_cnt1_o !== 8'd0) begin n_fail++; $display("FAIL reset_cnt1: got %0d expected 0", coin_cnt1_o); end
    coin_i = 2'b00;
    reset  = 1'b0;
    step(2);
  endtask

  task automatic test_single_pulse();
    int fr, lr, rr, fl, ll, rl, df;
    do_reset();
    coin_i = 2'b01;
    observe(40, 1, fr, lr, rr, fl, ll, rl, df);
    n_tests++; if (fr !== 7) begin n_fail++; $display("FAIL single_first_high: got %0d expected 7", fr); end
    n_tests++; if (lr !== 8) begin n_fail++; $display("FAIL single_pulse_len: got %0d expected 8", lr); end
    n_tests++; if (rr !== 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d expected 1", rr); end
    n_tests++; if (ll !== 0) begin n_fail++; $display("FAIL single_left_quiet: got %0d expected 0", ll); end
    n_tests++; if (coin_cnt0_o !== 8'd1) begin n_fail++; $display("FAIL single_cnt0: got %0d expected 1", coin_cnt0_o); end
    n_tests++; if (coin_cnt1_o !== 8'd0) begin n_fail++; $display("FAIL single_cnt1: got %0d expected 0", coin_cnt1_o); end
    coin_i = 2'b00;
    step(12);
  endtask

  task automatic test_glitch();
    int fr, lr, rr, fl, ll, rl, df;
    do_reset();
    coin_i = 2'b01;
    step(3);
    coin_i = 2'b00;
    observe(20, 1, fr, lr, rr, fl, ll, rl, df);
    n_tests++; if (lr !== 0) begin n_fail++; $display("FAIL glitch3_no_pulse: got %0d high cycles expected 0", lr); end
    n_tests++; if (coin_cnt0_o !== 8'd0) begin n_fail++; $display("FAIL glitch3_cnt0: got %0d expected 0", coin_cnt0_o); end
    // 4 cycles high still one tick short of acceptance.
    coin_i = 2'b01;
    step(4);
    coin_i = 2'b00;
    observe(20, 1, fr, lr, rr, fl, ll, rl, df);
    n_tests++; if (lr !== 0) begin n_fail++; $display("FAIL glitch4_no_pulse: got %0d high cycles expected 0", lr); end
    // 5 cycles high is the shortest press that is accepted.
    coin_i = 2'b01;
    step(5);
    coin_i = 2'b00;
    observe(25, 1, fr, lr, rr, fl, ll, rl, df);
    n_tests++; if (fr !== 2) begin n_fail++; $display("FAIL press5_first_high: got %0d expected 2", fr); end
    n_tests++; if (lr !== 8) begin n_fail++; $display("FAIL press5_pulse_len: got %0d expected 8", lr); end
    n_tests++; if (coin_cnt0_o !== 8'd1) begin n_fail++; $display("FAIL press5_cnt0: got %0d expected 1", coin_cnt0_o); end
  endtask

  task automatic test_both_channels();
    int fr, lr, rr, fl, ll, rl, df;
    do_reset();
    coin_i = 2'b11;
    observe(40, 1, fr, lr, rr, fl, ll, rl, df);
    n_tests++; if (fl !== 7) begin n_fail++; $display("FAIL both_left_first: got %0d expected 7", fl); end
    n_tests++; if (ll !== 8) begin n_fail++; $display("FAIL both_left_len: got %0d expected 8", ll); end
    n_tests++; if (fr !== 7) begin n_fail++; $display("FAIL both_right_first: got %0d expected 7", fr); end
    n_tests++; if (df !== 0) begin n_fail++; $display("FAIL both_same_cycles: got %0d differing cycles expected 0", df); end
    n_tests++; if (coin_cnt0_o !== 8'd1) begin n_fail++; $display("FAIL both_cnt0: got %0d expected 1", coin_cnt0_o); end
    n_tests++; if (coin_cnt1_o !== 8'd1) begin n_fail++; $display("FAIL both_cnt1: got %0d expected 1", coin_cnt1_o); end
    coin_i = 2'b00;
    step(12);
  endtask

  task automatic test_release_restart();
    int fr, lr, rr, fl, ll, rl, df;
    do_reset();
    coin_i = 2'b01;
    step(16);
    // Only 3 low ticks reach RELEASE before the button is pressed again.
    coin_i = 2'b00;
    step(3);
    coin_i = 2'b01;
    observe(30, 1, fr, lr, rr, fl, ll, rl, df);
    n_tests++; if (lr !== 0) begin n_fail++; $display("FAIL release_restart_no_pulse: got %0d high cycles expected 0", lr); end
    n_tests++; if (coin_cnt0_o !== 8'd1) begin n_fail++; $display("FAIL release_restart_cnt0: got %0d expected 1", coin_cnt0_o); end
    coin_i = 2'b00;
    step(12);
  endtask

  task automatic test_reset_mid_pulse();
    int fr, lr, rr, fl, ll, rl, df;
    do_reset();
    coin_i = 2'b01;
    step(9);
    n_tests++; if (right_chute_o !== 1'b1) begin n_fail++; $display("FAIL midpulse_high_before_reset: got %b expected 1", right_chute_o); end
    reset = 1'b1;
    step(1);
    n_tests++; if (right_chute_o !== 1'b0) begin n_fail++; $display("FAIL midpulse_drop: got %b expected 0", right_chute_o); end
    n_tests++; if (coin_cnt0_o !== 8'd0) begin n_fail++; $display("FAIL midpulse_cnt0_cleared: got %0d expected 0", coin_cnt0_o); end
    reset = 1'b0;
    observe(30, 1, fr, lr, rr, fl, ll, rl, df);
    n_tests++; if (fr !== 7) begin n_fail++; $display("FAIL midpulse_redebounce_first: got %0d expected 7", fr); end
    n_tests++; if (lr !== 8) begin n_fail++; $display("FAIL midpulse_redebounce_len: got %0d expected 8", lr); end
    n_tests++; if (coin_cnt0_o !== 8'd1) begin n_fail++; $display("FAIL midpulse_cnt0_after: got %0d expected 1", coin_cnt0_o); end
    coin_i = 2'b00;
    step(12);
  endtask

  task automatic test_ce_scaling();
    int fr, lr, rr, fl, ll, rl, df;
    do_reset();
    coin_i = 2'b01;
    observe(70, 4, fr, lr, rr, fl, ll, rl, df);
    n_tests++; if (fr !== 16) begin n_fail++; $display("FAIL ce4_first_high: got %0d expected 16", fr); end
    n_tests++; if (lr !== 32) begin n_fail++; $display("FAIL ce4_pulse_len: got %0d expected 32", lr); end
    n_tests++; if (rr !== 1) begin n_fail++; $display("FAIL ce4_pulse_count: got %0d expected 1", rr); end
    coin_i = 2'b00;
    step(12);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      coin_i = 2'b10;
      step(16);
      coin_i = 2'b00;
      step(12);
      if (k == 1) begin
        n_tests++; if (coin_cnt1_o !== 8'd1) begin n_fail++; $display("FAIL wrap_first_coin: got %0d expected 1", coin_cnt1_o); end
      end
      if (k == 255) begin
        n_tests++; if (coin_cnt1_o !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d expected 255", coin_cnt1_o); end
      end
    end
    n_tests++; if (coin_cnt1_o !== 8'd0) begin n_fail++; $display("FAIL wrap_to_zero: got %0d expected 0", coin_cnt1_o); end
    n_tests++; if (coin_cnt0_o !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt0_untouched: got %0d expected 0", coin_cnt0_o); end
  endtask

`ifdef LADYBUG_COIN_LOCKOUT_EN
  task automatic test_lockout();
    int fr, lr, rr, fl, ll, rl, df;
    do_reset();
    lockout_i = 1'b1;
    coin_i    = 2'b01;
    step(20);
    coin_i = 2'b00;
    observe(20, 1, fr, lr, rr, fl, ll, rl, df);
    n_tests++; if (lr !== 0) begin n_fail++; $display("FAIL lockout_block: got %0d high cycles expected 0", lr); end
    n_tests++; if (coin_cnt0_o !== 8'd0) begin n_fail++; $display("FAIL lockout_cnt0: got %0d expected 0", coin_cnt0_o); end
    lockout_i = 1'b0;
    coin_i    = 2'b01;
    step(4);
    lockout_i = 1'b1;
    observe(30, 1, fr, lr, rr, fl, ll, rl, df);
    n_tests++; if (fr !== 3) begin n_fail++; $display("FAIL lockout_late_first: got %0d expected 3", fr); end
    n_tests++; if (lr !== 8) begin n_fail++; $display("FAIL lockout_late_len: got %0d expected 8", lr); end
    lockout_i = 1'b0;
    coin_i    = 2'b00;
    step(12);
  endtask
`endif

  initial begin
    test_reset();
    test_single_pulse();
    test_glitch();
    test_both_channels();
    test_release_restart();
    test_reset_mid_pulse();
    test_ce_scaling();
    test_wrap();
`ifdef LADYBUG_COIN_LOCKOUT_EN
    test_lockout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
